// File: rtl/busmux_arb.sv
// busmux_arb: N-source bus arbiter with a registered output mux and a
// req/gnt/ack handshake. RR selects fixed priority (0, highest index wins)
// or round-robin (1). Optional ack timeout: define BUSMUX_ARB_TIMEOUT_EN.
module busmux_arb #(
    parameter int N       = 3,
    parameter int W       = 32,
    parameter int RR      = 0,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] src,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [N-1:0]   err,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    input  logic           out_ack
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] win;

`ifdef BUSMUX_ARB_TIMEOUT_EN
    logic [N-1:0] err_q;
    logic [15:0]  cnt;
    assign err = err_q;
`else
    assign err = '0;
`endif

    // Winner pick: highest set index, or first set bit after 'last' with wrap.
    // The RR scan runs backwards so the nearest candidate overwrites the rest.
    always_comb begin
        int idx;
        win = '0;
        idx = 0;
        if (RR == 0) begin
            for (int i = 0; i < N; i++)
                if (req[i]) win = IW'(i);
        end else begin
            for (int j = N; j >= 1; j--) begin
                idx = int'(last) + j;
                if (idx >= N) idx = idx - N;
                if (req[idx]) win = IW'(idx);
            end
        end
    end

    // Two-state handshake FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            done      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            last      <= IW'(N - 1);
`ifdef BUSMUX_ARB_TIMEOUT_EN
            err_q     <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // done/err only live for the single cycle after BUSY
                    done <= '0;
`ifdef BUSMUX_ARB_TIMEOUT_EN
                    err_q <= '0;
`endif
                    if (|req) begin
                        gnt       <= N'(1) << win;
                        out_valid <= 1'b1;
                        out_data  <= src[int'(win)*W +: W];
                        last      <= win;
                        state     <= BUSY;
`ifdef BUSMUX_ARB_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                BUSY: begin
                    // req/src are ignored here; ack beats a coincident timeout
                    if (out_ack) begin
                        done      <= gnt;
                        gnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
`ifdef BUSMUX_ARB_TIMEOUT_EN
                    else if (cnt == 16'(TIMEOUT - 1)) begin
                        err_q     <= gnt;
                        gnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
